// File: rtl/a_in_pkg.sv
// Shared types and constants for the module-A input sequencer.
// Word width, FSM state encoding and hold-counter sizing live here.
package a_in_pkg;

  localparam int unsigned A_IN_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } a_in_state_e;

  // Counter must hold HOLD_CYCLES-1; the floor of 1 bit keeps degenerate values legal.
  function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
    int unsigned w;
    w = $clog2(hold_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/a_in_fifo.sv
// DEPTH x A_IN_W synchronous FIFO with asynchronous active-low clear.
// A push into a full FIFO is dropped even when a pop happens on the same edge.
module a_in_fifo
  import a_in_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              CP,
  input  logic              CDN,
  input  logic              push,
  input  logic [A_IN_W-1:0] wdata,
  input  logic              pop,
  output logic [A_IN_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [A_IN_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers are power-of-two sized, so plain increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/a_in_sequencer.sv
// Stimulus sequencer for module A: buffers input words, holds each on A's inputs
// for HOLD_CYCLES cycles, then captures A's outputs into a handshaked result register.
module a_in_sequencer
  import a_in_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              CP,
  input  logic              CDN,
  inout  wire               VDD,
  inout  wire               VSS,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [A_IN_W-1:0] s_data,
  output logic              drv_in_A_one,
  output logic              drv_in_A_two,
  output logic              drv_in_A_three,
  output logic              drv_in_A_four,
  input  logic              smp_out_A_one,
  input  logic              smp_out_A_two,
  input  logic              smp_out_A_three,
  input  logic              smp_out_A,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [A_IN_W-1:0] r_data,
  output logic              busy
);

  localparam int unsigned CntW = hold_cnt_w(HOLD_CYCLES);

  a_in_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [A_IN_W-1:0] drv_q, drv_d;
  logic [A_IN_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [A_IN_W-1:0] fifo_rdata;
  logic              pop;
  logic              capture;
  logic [A_IN_W-1:0] smp_vec;

  assign smp_vec = {smp_out_A, smp_out_A_three, smp_out_A_two, smp_out_A_one};

  a_in_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CP    (CP),
    .CDN   (CDN),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM: state register
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = DRIVE;
      DRIVE:   if (cnt_q == '0) state_d = SAMPLE;
      SAMPLE:  if (!r_valid_q || r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: decoded outputs
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      IDLE: begin
        pop  = !fifo_empty;
        busy = 1'b0;
      end
      DRIVE: ;
      SAMPLE:  capture = !r_valid_q || r_ready;
      default: busy = 1'b0;
    endcase
  end

  // Drive registers load only on the pop edge, keeping A's inputs stable until the next pop.
  always_comb begin
    cnt_d     = cnt_q;
    drv_d     = drv_q;
    r_data_d  = r_data_q;
    r_valid_d = r_valid_q;
    if (pop) begin
      drv_d = fifo_rdata;
      cnt_d = CntW'(HOLD_CYCLES - 1);
    end else if ((state_q == DRIVE) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
    // A capture on the consume edge reloads the result and keeps it valid.
    if (capture) begin
      r_data_d  = smp_vec;
      r_valid_d = 1'b1;
    end else if (r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      cnt_q     <= '0;
      drv_q     <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      drv_q     <= drv_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign s_ready        = !fifo_full;
  assign r_valid        = r_valid_q;
  assign r_data         = r_data_q;
  assign drv_in_A_one   = drv_q[0];
  assign drv_in_A_two   = drv_q[1];
  assign drv_in_A_three = drv_q[2];
  assign drv_in_A_four  = drv_q[3];

endmodule

// File: tb/tb_a_in_sequencer.sv
// Directed bench for a_in_sequencer with a scoreboard of expected drive words and results.
// Module A is modelled as a fixed XOR so every result is predictable from its drive word.
module tb_a_in_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       d1, d2, d3, d4;
  logic       r_valid;
  logic       r_ready;
  logic [3:0] r_data;
  logic       busy;
  logic [3:0] drv;
  logic [3:0] smp;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_drv_q[$];
  logic [3:0] exp_res_q[$];
  logic [3:0] cur_word = 4'h0;
  int         occ = 0;
  logic       busy_prev = 1'b0;
  logic       acc_last = 1'b0;

  function automatic logic [3:0] a_model(input logic [3:0] x);
    return x ^ 4'hC;
  endfunction

  assign drv = {d4, d3, d2, d1};
  assign smp = a_model(drv);

  always #5 clk = ~clk;

  a_in_sequencer #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CP              (clk),
    .CDN             (rst_n),
    .VDD             (vdd),
    .VSS             (vss),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .drv_in_A_one    (d1),
    .drv_in_A_two    (d2),
    .drv_in_A_three  (d3),
    .drv_in_A_four   (d4),
    .smp_out_A_one   (smp[0]),
    .smp_out_A_two   (smp[1]),
    .smp_out_A_three (smp[2]),
    .smp_out_A       (smp[3]),
    .r_valid         (r_valid),
    .r_ready         (r_ready),
    .r_data          (r_data),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: account for handshakes before the edge, check pops and drive after it.
  task automatic step();
    logic [3:0] w;
    acc_last = s_valid && s_ready;
    if (acc_last) begin
      exp_drv_q.push_back(s_data);
      occ++;
    end
    if (r_valid && r_ready) begin
      total++;
      assert (exp_res_q.size() != 0)
      else begin
        bad++;
        $error("FAIL unexpected_result observed=%h expected=none", r_data);
      end
      if (exp_res_q.size() != 0) chk("result_data", r_data, exp_res_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (busy && !busy_prev) begin
      total++;
      assert (exp_drv_q.size() != 0)
      else begin
        bad++;
        $error("FAIL unexpected_pop observed=%h expected=none", drv);
      end
      if (exp_drv_q.size() != 0) begin
        w        = exp_drv_q.pop_front();
        cur_word = w;
        occ--;
        exp_res_q.push_back(a_model(w));
        chk("drv_pop", drv, w);
      end
    end else begin
      chk(busy ? "drv_hold" : "drv_idle", drv, cur_word);
    end
    chk("s_ready", 4'(s_ready), 4'(occ != int'(DEPTH)));
    busy_prev = busy;
  endtask

  task automatic push_word(input logic [3:0] d);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      step();
      n++;
    end while (!acc_last && n < 200);
    total++;
    assert (acc_last)
    else begin
      bad++;
      $error("FAIL push_timeout observed=%0d expected=<200", n);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_drv_q.size() != 0 || exp_res_q.size() != 0 || busy || r_valid) && n < 400) begin
      step();
      n++;
    end
    total++;
    assert (n < 400)
    else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=<400", n);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_drv"}, drv, 4'h0);
    chk({tag, "_r_valid"}, 4'(r_valid), 4'h0);
    chk({tag, "_r_data"}, r_data, 4'h0);
    chk({tag, "_busy"}, 4'(busy), 4'h0);
    chk({tag, "_s_ready"}, 4'(s_ready), 4'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset held with s_valid asserted
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 4'hF;
    r_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_release_busy", 4'(busy), 4'h0);

    // Single word latency
    r_ready = 1'b1;
    push_word(4'b1010);
    step();
    chk("lat_drv_two", 4'(d2), 4'h1);
    chk("lat_drv_four", 4'(d4), 4'h1);
    chk("lat_drv_one", 4'(d1), 4'h0);
    chk("lat_busy", 4'(busy), 4'h1);
    step();
    chk("lat_rvalid_e2", 4'(r_valid), 4'h0);
    step();
    chk("lat_rvalid_e3", 4'(r_valid), 4'h0);
    step();
    chk("lat_rvalid_e4", 4'(r_valid), 4'h1);
    chk("lat_rdata_e4", r_data, 4'b0110);
    chk("lat_busy_e4", 4'(busy), 4'h0);
    drain();

    // Fill with the result side stalled
    r_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(4'(i));
    chk("fill_full", 4'(s_ready), 4'h0);
    // Pop from a full FIFO must not open a slot for a push on the same edge
    s_valid = 1'b1;
    s_data  = 4'h6;
    step();
    chk("full_pop_nopush", 4'(acc_last), 4'h0);
    step();
    chk("push_after_pop", 4'(acc_last), 4'h1);
    s_valid = 1'b0;
    repeat (8) step();
    chk("stall_rvalid", 4'(r_valid), 4'h1);
    chk("stall_busy", 4'(busy), 4'h1);
    chk("stall_rdata", r_data, a_model(4'h1));
    // Consume on the capture edge: result reloads and stays valid
    r_ready = 1'b1;
    step();
    chk("cap_hs_rvalid", 4'(r_valid), 4'h1);
    chk("cap_hs_rdata", r_data, a_model(4'h2));
    drain();

    // Stream across pointer wraps
    for (int i = 0; i < 10; i++) push_word(4'(i));
    drain();

    // Reset mid-DRIVE with three words queued
    for (int i = 0; i < 5; i++) push_word(4'(4'hA + i));
    step();
    chk("mid_busy", 4'(busy), 4'h1);
    chk("mid_occ", 4'(occ), 4'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_drv_q.delete();
    exp_res_q.delete();
    occ       = 0;
    cur_word  = 4'h0;
    busy_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_busy", 4'(busy), 4'h0);
    chk("post_rst_rvalid", 4'(r_valid), 4'h0);
    chk("post_rst_drv", drv, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
